// File: rtl/req_arb4.sv
// Four-requester round-robin arbiter driving the select of a 4:1 mux; owner holds until release or request drop.
// Optional watchdog forced release when ARB_TIMEOUT_EN is defined; the release input is named rel because release is a reserved word.
module req_arb4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] sel_nx;
  logic [3:0] grant_nx;
  logic [1:0] pick;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             timeout_nx;
`endif

  // Scan from the farthest offset down so the set bit closest to ptr wins.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    grant_nx = grant;
`ifdef ARB_TIMEOUT_EN
    cnt_nx     = cnt;
    timeout_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_nx   = pick;
          grant_nx = 4'b0001 << pick;
          state_nx = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      GRANT: begin
        // A voluntary end always beats the watchdog, so timeout stays low then.
        if (rel || !req[sel]) begin
          grant_nx = 4'b0000;
          ptr_nx   = sel + 2'd1;
          state_nx = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(MAX_HOLD - 1)) begin
          grant_nx   = 4'b0000;
          ptr_nx     = sel + 2'd1;
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      grant <= 4'b0000;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
      grant <= grant_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      timeout <= timeout_nx;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state == GRANT);

endmodule
